// File: rtl/sc_microsequencer_pkg.sv
// Shared types, constants and the default micro-program image for sc_microsequencer.
package sc_microsequencer_pkg;

  localparam int unsigned DATAWIDTH_DECODER_SELECTION = 6;
  localparam int unsigned DATAWIDTH_MUX_SELECTION     = 6;
  localparam int unsigned DATAWIDTH_ALU_SELECTION     = 4;
  localparam int unsigned DATAWIDTH_UPC               = 5;
  localparam int unsigned ROM_DEPTH                   = 1 << DATAWIDTH_UPC;

  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DATA_DECODER_NOWRITE = 6'd63;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

  localparam logic [2:0] COND_NEXT = 3'd0;
  localparam logic [2:0] COND_JUMP = 3'd1;
  localparam logic [2:0] COND_BZ   = 3'd2;
  localparam logic [2:0] COND_BN   = 3'd3;
  localparam logic [2:0] COND_BC   = 3'd4;
  localparam logic [2:0] COND_BV   = 3'd5;
  localparam logic [2:0] COND_BNZ  = 3'd6;
  localparam logic [2:0] COND_HALT = 3'd7;

  // Field layout, MSB first: wr[31:26] bus_a[25:20] bus_b[19:14] alu[13:10]
  // shload_n[9] shsel_n[8] cond[7:5] target[4:0].
  typedef struct packed {
    logic [DATAWIDTH_DECODER_SELECTION-1:0] wr;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     bus_a;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     bus_b;
    logic [DATAWIDTH_ALU_SELECTION-1:0]     alu;
    logic                                   shload_n;
    logic                                   shsel_n;
    logic [2:0]                             cond;
    logic [DATAWIDTH_UPC-1:0]               target;
  } uinstr_t;

  typedef logic [ROM_DEPTH-1:0][31:0] rom_image_t;

  function automatic rom_image_t build_rom_image();
    rom_image_t img;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      img[i] = {DATA_DECODER_NOWRITE, 6'd0, 6'd0, 4'd0, 1'b1, 1'b1, COND_HALT, 5'd0};
    end
    img[0] = {6'd5, 6'd2, 6'd3, 4'd4, 1'b1, 1'b1, COND_HALT, 5'd0};
    return img;
  endfunction

  localparam rom_image_t ROM_IMAGE = build_rom_image();

endpackage

// File: rtl/sc_microsequencer_if.sv
// Control/status bundle between the microsequencer (master) and the datapath side (slave).
// Optional SC_MICROSEQUENCER_SINGLESTEP_EN adds the Step input.
interface sc_microsequencer_if;
  import sc_microsequencer_pkg::*;

  logic                                   SC_MICROSEQUENCER_Start_InHigh;
  logic                                   SC_MICROSEQUENCER_Overflow_InLow;
  logic                                   SC_MICROSEQUENCER_Carry_InLow;
  logic                                   SC_MICROSEQUENCER_Negative_InLow;
  logic                                   SC_MICROSEQUENCER_Zero_InLow;
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
  logic                                   SC_MICROSEQUENCER_Step_InHigh;
`endif
  logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_MICROSEQUENCER_DecoderSelectionWrite_Out;
  logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQUENCER_MUXSelectionBUSA_Out;
  logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQUENCER_MUXSelectionBUSB_Out;
  logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_MICROSEQUENCER_ALUSelection_Out;
  logic                                   SC_MICROSEQUENCER_RegSHIFTERLoad_OutLow;
  logic                                   SC_MICROSEQUENCER_RegSHIFTERShiftSelection_OutLow;
  logic                                   SC_MICROSEQUENCER_Busy_OutHigh;
  logic                                   SC_MICROSEQUENCER_Done_OutHigh;
  logic [DATAWIDTH_UPC-1:0]               SC_MICROSEQUENCER_uPC_Out;

  modport master (
    input  SC_MICROSEQUENCER_Start_InHigh,
    input  SC_MICROSEQUENCER_Overflow_InLow,
    input  SC_MICROSEQUENCER_Carry_InLow,
    input  SC_MICROSEQUENCER_Negative_InLow,
    input  SC_MICROSEQUENCER_Zero_InLow,
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
    input  SC_MICROSEQUENCER_Step_InHigh,
`endif
    output SC_MICROSEQUENCER_DecoderSelectionWrite_Out,
    output SC_MICROSEQUENCER_MUXSelectionBUSA_Out,
    output SC_MICROSEQUENCER_MUXSelectionBUSB_Out,
    output SC_MICROSEQUENCER_ALUSelection_Out,
    output SC_MICROSEQUENCER_RegSHIFTERLoad_OutLow,
    output SC_MICROSEQUENCER_RegSHIFTERShiftSelection_OutLow,
    output SC_MICROSEQUENCER_Busy_OutHigh,
    output SC_MICROSEQUENCER_Done_OutHigh,
    output SC_MICROSEQUENCER_uPC_Out
  );

  modport slave (
    output SC_MICROSEQUENCER_Start_InHigh,
    output SC_MICROSEQUENCER_Overflow_InLow,
    output SC_MICROSEQUENCER_Carry_InLow,
    output SC_MICROSEQUENCER_Negative_InLow,
    output SC_MICROSEQUENCER_Zero_InLow,
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
    output SC_MICROSEQUENCER_Step_InHigh,
`endif
    input  SC_MICROSEQUENCER_DecoderSelectionWrite_Out,
    input  SC_MICROSEQUENCER_MUXSelectionBUSA_Out,
    input  SC_MICROSEQUENCER_MUXSelectionBUSB_Out,
    input  SC_MICROSEQUENCER_ALUSelection_Out,
    input  SC_MICROSEQUENCER_RegSHIFTERLoad_OutLow,
    input  SC_MICROSEQUENCER_RegSHIFTERShiftSelection_OutLow,
    input  SC_MICROSEQUENCER_Busy_OutHigh,
    input  SC_MICROSEQUENCER_Done_OutHigh,
    input  SC_MICROSEQUENCER_uPC_Out
  );

endinterface

// File: rtl/sc_microsequencer_rom.sv
// Combinational 32-word micro-instruction store, contents fixed at elaboration.
module sc_microsequencer_rom
  import sc_microsequencer_pkg::*;
#(
  parameter rom_image_t RomImage = ROM_IMAGE
) (
  input  logic [DATAWIDTH_UPC-1:0] addr_i,
  output uinstr_t                  data_o
);

  assign data_o = uinstr_t'(RomImage[addr_i]);

endmodule

// File: rtl/sc_microsequencer.sv
// Microprogrammed controller for uDataPath: FETCH/EXEC per micro-instruction, flag branches.
// SC_MICROSEQUENCER_SINGLESTEP_EN gates FETCH->EXEC on the Step input.
module sc_microsequencer
  import sc_microsequencer_pkg::*;
#(
  parameter rom_image_t RomImage = ROM_IMAGE
) (
  input  logic                SC_MICROSEQUENCER_CLOCK_50,
  input  logic                SC_MICROSEQUENCER_Reset_InHigh,
  sc_microsequencer_if.master bus
);

  state_e                   state_q, state_d;
  logic [DATAWIDTH_UPC-1:0] upc_q, upc_d;
  uinstr_t                  ir_q, ir_d;
  uinstr_t                  rom_data;
  logic                     taken;
  logic                     fetch_go;

  sc_microsequencer_rom #(
    .RomImage(RomImage)
  ) u_rom (
    .addr_i(upc_q),
    .data_o(rom_data)
  );

`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
  assign fetch_go = bus.SC_MICROSEQUENCER_Step_InHigh;
`else
  assign fetch_go = 1'b1;
`endif

  // Flags are active-low; the branch sees the flags of its own EXEC cycle.
  always_comb begin
    taken = 1'b0;
    case (ir_q.cond)
      COND_JUMP: taken = 1'b1;
      COND_BZ:   taken = ~bus.SC_MICROSEQUENCER_Zero_InLow;
      COND_BN:   taken = ~bus.SC_MICROSEQUENCER_Negative_InLow;
      COND_BC:   taken = ~bus.SC_MICROSEQUENCER_Carry_InLow;
      COND_BV:   taken = ~bus.SC_MICROSEQUENCER_Overflow_InLow;
      COND_BNZ:  taken = bus.SC_MICROSEQUENCER_Zero_InLow;
      default:   taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle: begin
        if (bus.SC_MICROSEQUENCER_Start_InHigh) begin
          state_d = StFetch;
          upc_d   = '0;
        end
      end
      StFetch: begin
        ir_d = rom_data;
        if (fetch_go) state_d = StExec;
      end
      StExec: begin
        if (ir_q.cond == COND_HALT) begin
          state_d = StDone;
        end else begin
          state_d = StFetch;
          upc_d   = taken ? ir_q.target : upc_q + 5'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SC_MICROSEQUENCER_CLOCK_50) begin
    if (SC_MICROSEQUENCER_Reset_InHigh) begin
      state_q <= StIdle;
      upc_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    bus.SC_MICROSEQUENCER_DecoderSelectionWrite_Out       = DATA_DECODER_NOWRITE;
    bus.SC_MICROSEQUENCER_MUXSelectionBUSA_Out            = '0;
    bus.SC_MICROSEQUENCER_MUXSelectionBUSB_Out            = '0;
    bus.SC_MICROSEQUENCER_ALUSelection_Out                = '0;
    bus.SC_MICROSEQUENCER_RegSHIFTERLoad_OutLow           = 1'b1;
    bus.SC_MICROSEQUENCER_RegSHIFTERShiftSelection_OutLow = 1'b1;
    if (state_q == StExec) begin
      bus.SC_MICROSEQUENCER_DecoderSelectionWrite_Out       = ir_q.wr;
      bus.SC_MICROSEQUENCER_MUXSelectionBUSA_Out            = ir_q.bus_a;
      bus.SC_MICROSEQUENCER_MUXSelectionBUSB_Out            = ir_q.bus_b;
      bus.SC_MICROSEQUENCER_ALUSelection_Out                = ir_q.alu;
      bus.SC_MICROSEQUENCER_RegSHIFTERLoad_OutLow           = ir_q.shload_n;
      bus.SC_MICROSEQUENCER_RegSHIFTERShiftSelection_OutLow = ir_q.shsel_n;
    end
    bus.SC_MICROSEQUENCER_Busy_OutHigh = (state_q == StFetch) || (state_q == StExec);
    bus.SC_MICROSEQUENCER_Done_OutHigh = (state_q == StDone);
    bus.SC_MICROSEQUENCER_uPC_Out      = upc_q;
  end

endmodule

// File: tb/tb_sc_microsequencer.sv
// Randomized scoreboard bench for sc_microsequencer with its own micro-program image.
module tb_sc_microsequencer;

  typedef logic [31:0][31:0] img_t;

  typedef struct packed {
    logic [5:0] wr;
    logic [5:0] a;
    logic [5:0] b;
    logic [3:0] alu;
    logic       shl;
    logic       shs;
    logic       busy;
    logic       done;
    logic [4:0] upc;
    logic       chk_upc;
  } exp_t;

  function automatic logic [31:0] mi(int wr, int a, int b, int alu, int shl, int shs,
                                     int cnd, int tgt);
    return {6'(wr), 6'(a), 6'(b), 4'(alu), 1'(shl), 1'(shs), 3'(cnd), 5'(tgt)};
  endfunction

  // cond: 0 NEXT 1 JUMP 2 BZ 3 BN 4 BC 5 BV 6 BNZ 7 HALT
  function automatic img_t build_image();
    img_t img;
    for (int i = 0; i < 32; i++) img[i] = mi(i, (i * 3) % 64, (i * 5) % 64, i % 16, 1, 1, 7, 0);
    img[0]  = mi(5, 2, 3, 4, 1, 1, 2, 7);
    img[1]  = mi(1, 1, 0, 1, 0, 1, 0, 0);
    img[2]  = mi(2, 4, 5, 2, 1, 0, 3, 9);
    img[3]  = mi(3, 6, 7, 3, 1, 1, 4, 20);
    img[4]  = mi(4, 8, 9, 5, 0, 0, 0, 0);
    img[5]  = mi(6, 10, 11, 6, 1, 1, 5, 30);
    img[6]  = mi(10, 12, 13, 7, 1, 1, 7, 0);
    img[7]  = mi(7, 14, 15, 8, 1, 0, 6, 2);
    img[8]  = mi(8, 0, 0, 9, 1, 1, 7, 0);
    img[9]  = mi(9, 16, 17, 10, 1, 1, 1, 31);
    img[20] = mi(20, 1, 2, 11, 1, 1, 4, 31);
    img[21] = mi(21, 3, 4, 12, 1, 1, 7, 0);
    img[30] = mi(63, 0, 0, 0, 1, 1, 1, 31);
    img[31] = mi(31, 5, 6, 13, 0, 1, 0, 0);
    return img;
  endfunction

  localparam img_t TbImage = build_image();

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sc_microsequencer_if bus();

  sc_microsequencer #(
    .RomImage(TbImage)
  ) dut (
    .SC_MICROSEQUENCER_CLOCK_50    (clk),
    .SC_MICROSEQUENCER_Reset_InHigh(rst),
    .bus                           (bus)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t mon_e, mon_a;

  // Monitor: one expected vector per checked cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e         = exp_q.pop_front();
      mon_a.wr      = bus.SC_MICROSEQUENCER_DecoderSelectionWrite_Out;
      mon_a.a       = bus.SC_MICROSEQUENCER_MUXSelectionBUSA_Out;
      mon_a.b       = bus.SC_MICROSEQUENCER_MUXSelectionBUSB_Out;
      mon_a.alu     = bus.SC_MICROSEQUENCER_ALUSelection_Out;
      mon_a.shl     = bus.SC_MICROSEQUENCER_RegSHIFTERLoad_OutLow;
      mon_a.shs     = bus.SC_MICROSEQUENCER_RegSHIFTERShiftSelection_OutLow;
      mon_a.busy    = bus.SC_MICROSEQUENCER_Busy_OutHigh;
      mon_a.done    = bus.SC_MICROSEQUENCER_Done_OutHigh;
      mon_a.upc     = mon_e.chk_upc ? bus.SC_MICROSEQUENCER_uPC_Out : mon_e.upc;
      mon_a.chk_upc = mon_e.chk_upc;
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL outputs t=%0t actual wr=%0d a=%0d b=%0d alu=%0d shl=%b shs=%b busy=%b done=%b upc=%0d required wr=%0d a=%0d b=%0d alu=%0d shl=%b shs=%b busy=%b done=%b upc=%0d",
                 $time, mon_a.wr, mon_a.a, mon_a.b, mon_a.alu, mon_a.shl, mon_a.shs, mon_a.busy,
                 mon_a.done, mon_a.upc, mon_e.wr, mon_e.a, mon_e.b, mon_e.alu, mon_e.shl,
                 mon_e.shs, mon_e.busy, mon_e.done, mon_e.upc);
      end
    end
  end

  function automatic exp_t idle_exp(bit chk, int upc);
    exp_t e;
    e = '{wr: 6'd63, a: 6'd0, b: 6'd0, alu: 4'd0, shl: 1'b1, shs: 1'b1,
          busy: 1'b0, done: 1'b0, upc: 5'(upc), chk_upc: chk};
    return e;
  endfunction

  function automatic exp_t fetch_exp(int pc);
    exp_t e;
    e      = idle_exp(1'b1, pc);
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t exec_exp(logic [31:0] w, int pc);
    exp_t e;
    e = '{wr: w[31:26], a: w[25:20], b: w[19:14], alu: w[13:10], shl: w[9], shs: w[8],
          busy: 1'b1, done: 1'b0, upc: 5'(pc), chk_upc: 1'b1};
    return e;
  endfunction

  // f = {overflow_n, carry_n, negative_n, zero_n}
  function automatic bit cond_true(int c, logic [3:0] f);
    case (c)
      1:       return 1'b1;
      2:       return !f[0];
      3:       return !f[1];
      4:       return !f[2];
      5:       return !f[3];
      6:       return f[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_flags(logic [3:0] f);
    bus.SC_MICROSEQUENCER_Zero_InLow     = f[0];
    bus.SC_MICROSEQUENCER_Negative_InLow = f[1];
    bus.SC_MICROSEQUENCER_Carry_InLow    = f[2];
    bus.SC_MICROSEQUENCER_Overflow_InLow = f[3];
  endtask

  task automatic drive_noise();
    bus.SC_MICROSEQUENCER_Start_InHigh = 1'($urandom);
    drive_flags(4'($urandom));
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
    bus.SC_MICROSEQUENCER_Step_InHigh = 1'($urandom);
`endif
  endtask

  task automatic run_program();
    int         pcs[$];
    logic [3:0] fls[$];
    int         pc;
    int         abort_at;
    bit         halted;
    pc     = 0;
    halted = 1'b0;
    // Plan the whole run at the instruction level, choosing flags per EXEC.
    for (int k = 0; k < 100 && !halted; k++) begin
      logic [31:0] w;
      logic [3:0]  f;
      w = TbImage[pc];
      f = 4'($urandom);
      pcs.push_back(pc);
      fls.push_back(f);
      if (int'(w[7:5]) == 7) halted = 1'b1;
      else if (cond_true(int'(w[7:5]), f)) pc = int'(w[4:0]);
      else pc = (pc + 1) % 32;
    end
    if (!halted) abort_at = pcs.size() - 1;
    else if ($urandom_range(3) == 0) abort_at = int'($urandom_range(pcs.size() - 1));
    else abort_at = -1;

    tick();
    drive_noise();
    bus.SC_MICROSEQUENCER_Start_InHigh = 1'b1;
    exp_q.push_back(idle_exp(1'b0, 0));
    for (int i = 0; i < pcs.size(); i++) begin
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
      repeat ($urandom_range(11)) begin
        tick();
        drive_noise();
        bus.SC_MICROSEQUENCER_Step_InHigh = 1'b0;
        exp_q.push_back(fetch_exp(pcs[i]));
      end
      tick();
      drive_noise();
      bus.SC_MICROSEQUENCER_Step_InHigh = 1'b1;
      exp_q.push_back(fetch_exp(pcs[i]));
`else
      tick();
      drive_noise();
      exp_q.push_back(fetch_exp(pcs[i]));
`endif
      tick();
      drive_noise();
      drive_flags(fls[i]);
      if (i == abort_at) rst = 1'b1;
      exp_q.push_back(exec_exp(TbImage[pcs[i]], pcs[i]));
      if (i == abort_at) begin
        tick();
        rst = 1'b0;
        bus.SC_MICROSEQUENCER_Start_InHigh = 1'b0;
        exp_q.push_back(idle_exp(1'b1, 0));
        return;
      end
    end
    tick();
    drive_noise();
    begin
      exp_t d;
      d      = idle_exp(1'b0, 0);
      d.done = 1'b1;
      exp_q.push_back(d);
    end
    tick();
    drive_noise();
    bus.SC_MICROSEQUENCER_Start_InHigh = 1'b0;
    exp_q.push_back(idle_exp(1'b0, 0));
  endtask

  initial begin
    rst = 1'b1;
    bus.SC_MICROSEQUENCER_Start_InHigh = 1'b0;
    drive_flags(4'hF);
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
    bus.SC_MICROSEQUENCER_Step_InHigh = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    exp_q.push_back(idle_exp(1'b1, 0));
    repeat (4) begin
      tick();
      drive_flags(4'($urandom));
      exp_q.push_back(idle_exp(1'b1, 0));
    end
    repeat (60) run_program();
    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
